// File: rtl/fetch_queue_if.sv
// Fetch queue bus: PC-stage request, instruction-memory return, decode handshake and flush.
// master = pipeline side driving requests/returns/decode-ready, slave = the fetch_queue itself.
interface fetch_queue_if #(
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic          req_valid;
   logic [31:0]   req_pc;
   logic          fq_ready;
   logic [31:0]   im_dout;
   logic          flush;
   logic          id_ready;
   logic          id_valid;
   logic [31:0]   id_pc;
   logic [31:0]   id_inst;
   logic [CW-1:0] fq_count;

   modport master (
      output req_valid, req_pc, im_dout, flush, id_ready,
      input  fq_ready, id_valid, id_pc, id_inst, fq_count
   );

   modport slave (
      input  req_valid, req_pc, im_dout, flush, id_ready,
      output fq_ready, id_valid, id_pc, id_inst, fq_count
   );
endinterface

// File: rtl/fetch_queue.sv
// Fetch queue between instruction fetch and decode. Tracks the single outstanding
// instruction-memory read (data returns one cycle after the address), pairs the returned
// instruction with its PC and buffers the pair in a DEPTH-entry FIFO.
// Optional macro FQ_BYPASS_EN adds a zero-latency path from im_dout to id_* when the queue
// is empty; without it id_* comes from registered state only.
module fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input logic          clk,
   input logic          rst,
   fetch_queue_if.slave fq
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

   logic [CW-1:0] count_q;
   logic [PW-1:0] rd_ptr_q;
   logic [PW-1:0] wr_ptr_q;
   logic          inflight_q;
   logic [31:0]   inflight_pc_q;
   logic [31:0]   pc_mem   [DEPTH];
   logic [31:0]   inst_mem [DEPTH];

   logic          head_valid;
   logic [CW:0]   occupancy;
   logic          accept;
   logic          byp;
   logic          push;
   logic          pop;

   // Handshake decode; fq_ready reserves a slot for the in-flight fetch so a return always fits.
   always_comb begin
      head_valid  = (count_q != '0);
      occupancy   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
      fq.fq_ready = (occupancy < DEPTH_W);
      accept      = fq.req_valid & fq.fq_ready & ~fq.flush;
`ifdef FQ_BYPASS_EN
      byp         = ~head_valid & inflight_q & ~fq.flush;
`else
      byp         = 1'b0;
`endif
      // A bypassed response taken by decode this cycle never enters the FIFO.
      push        = inflight_q & ~fq.flush & ~(byp & fq.id_ready);
      pop         = head_valid & fq.id_ready & ~fq.flush;
   end

   // Decode-side outputs; idle value is a NOP so decode never sees X.
   always_comb begin
      fq.id_valid = head_valid | byp;
      fq.fq_count = count_q;
      if (head_valid) begin
         fq.id_pc   = pc_mem[rd_ptr_q];
         fq.id_inst = inst_mem[rd_ptr_q];
`ifdef FQ_BYPASS_EN
      end else if (byp) begin
         fq.id_pc   = inflight_pc_q;
         fq.id_inst = fq.im_dout;
`endif
      end else begin
         fq.id_pc   = 32'h0;
         fq.id_inst = NOP_INST;
      end
   end

   // Control state: flush wipes everything, including the in-flight fetch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q       <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         inflight_q    <= 1'b0;
         inflight_pc_q <= 32'h0;
      end else if (fq.flush) begin
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= accept;
         if (accept) inflight_pc_q <= fq.req_pc;
         if (push)   wr_ptr_q      <= wr_ptr_q + PW'(1);
         if (pop)    rd_ptr_q      <= rd_ptr_q + PW'(1);
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

   // Entry storage; im_dout is only sampled while a fetch is outstanding.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr_q]   <= inflight_pc_q;
         inst_mem[wr_ptr_q] <= fq.im_dout;
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue. A scoreboard queue receives each fetch when it is
// accepted and the head is compared on every cycle decode could see it. Honours FQ_BYPASS_EN.
module tb_fetch_queue;
   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam logic [31:0] JUNK  = 32'hDEAD_BEEF;
`ifdef FQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   logic clk;
   logic rst;

   fetch_queue_if #(.DEPTH(DEPTH)) fq_bus ();

   fetch_queue #(
      .DEPTH   (DEPTH),
      .NOP_INST(NOP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .fq (fq_bus)
   );

   int          checks = 0;
   int          errors = 0;
   ent_t        sb[$];
   int          m_count;
   bit          m_inflight;
   bit          last_acc;
   logic [31:0] last_pc;
   logic [31:0] next_pc;
   bit          junk;

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Global time limit.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "time limit");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      sb.delete();
      m_count    = 0;
      m_inflight = 1'b0;
      last_acc   = 1'b0;
   endtask

   // One clock cycle: entered 1 time unit after a rising edge, leaves at the same point.
   task automatic do_cycle(input bit want_req, input bit rdy, input bit fl);
      bit exp_ready, exp_valid, accept, byp_take, push, popq;
      exp_ready = (m_count + int'(m_inflight)) < DEPTH;
      exp_valid = (m_count != 0) || (BYP && m_inflight && !fl);
      if (last_acc)  fq_bus.im_dout = 32'h1000 + last_pc;
      else if (junk) fq_bus.im_dout = JUNK;
      else           fq_bus.im_dout = 'x;
      fq_bus.req_valid = want_req & exp_ready;
      fq_bus.req_pc    = next_pc;
      fq_bus.id_ready  = rdy;
      fq_bus.flush     = fl;
      #2;
      chk("fq_ready", 32'(fq_bus.fq_ready), 32'(exp_ready));
      chk("fq_count", 32'(fq_bus.fq_count), 32'(m_count));
      chk("id_valid", 32'(fq_bus.id_valid), 32'(exp_valid));
      if (fq_bus.req_valid) chk("req_while_not_ready", 32'(fq_bus.fq_ready), 32'd1);
      if (exp_valid && sb.size() > 0) begin
         chk("id_pc", fq_bus.id_pc, sb[0].pc);
         chk("id_inst", fq_bus.id_inst, sb[0].inst);
      end else begin
         chk("idle_id_pc", fq_bus.id_pc, 32'h0);
         chk("idle_id_inst", fq_bus.id_inst, NOP);
      end
      accept   = fq_bus.req_valid && exp_ready && !fl;
      byp_take = BYP && m_count == 0 && m_inflight && !fl && rdy;
      push     = m_inflight && !fl && !byp_take;
      popq     = m_count != 0 && rdy && !fl;
      if (exp_valid && rdy && !fl && sb.size() > 0) void'(sb.pop_front());
      m_count = m_count + int'(push) - int'(popq);
      if (accept) begin
         sb.push_back('{pc: next_pc, inst: 32'h1000 + next_pc});
         last_pc = next_pc;
         next_pc = next_pc + 32'd4;
      end
      last_acc   = accept;
      m_inflight = accept;
      if (fl) model_reset();
      @(posedge clk);
      #1;
   endtask

   // Directed sequence.
   initial begin
      rst              = 1'b1;
      fq_bus.req_valid = 1'b0;
      fq_bus.req_pc    = 32'h0;
      fq_bus.im_dout   = 'x;
      fq_bus.flush     = 1'b0;
      fq_bus.id_ready  = 1'b0;
      junk             = 1'b0;
      next_pc          = 32'h0;
      last_pc          = 32'h0;
      model_reset();
      #2;
      chk("rst_id_valid", 32'(fq_bus.id_valid), 32'd0);
      chk("rst_id_pc", fq_bus.id_pc, 32'h0);
      chk("rst_id_inst", fq_bus.id_inst, NOP);
      chk("rst_fq_ready", 32'(fq_bus.fq_ready), 32'd1);
      chk("rst_fq_count", 32'(fq_bus.fq_count), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Streaming with decode always ready.
      repeat (8) do_cycle(1'b1, 1'b1, 1'b0);
      repeat (3) do_cycle(1'b0, 1'b1, 1'b0);

      // Stall decode until full, one pop, refill into the wrapped slot, then drain.
      repeat (8) do_cycle(1'b1, 1'b0, 1'b0);
      do_cycle(1'b1, 1'b1, 1'b0);
      do_cycle(1'b1, 1'b0, 1'b0);
      repeat (3) do_cycle(1'b0, 1'b0, 1'b0);
      repeat (6) do_cycle(1'b0, 1'b1, 1'b0);

      // Flush with two buffered and one in flight, request in the flush cycle dropped.
      next_pc = 32'h100;
      repeat (3) do_cycle(1'b1, 1'b0, 1'b0);
      junk = 1'b1;
      do_cycle(1'b1, 1'b0, 1'b1);
      do_cycle(1'b0, 1'b0, 1'b0);
      junk    = 1'b0;
      next_pc = 32'h200;
      do_cycle(1'b1, 1'b1, 1'b0);
      repeat (3) do_cycle(1'b0, 1'b1, 1'b0);

      // Asynchronous reset with three entries and one fetch outstanding.
      next_pc = 32'h300;
      repeat (4) do_cycle(1'b1, 1'b0, 1'b0);
      chk("pre_rst_count", 32'(fq_bus.fq_count), 32'd3);
      fq_bus.im_dout   = 32'h1000 + last_pc;
      fq_bus.req_valid = 1'b0;
      rst              = 1'b1;
      #1;
      chk("async_rst_id_valid", 32'(fq_bus.id_valid), 32'd0);
      chk("async_rst_id_pc", fq_bus.id_pc, 32'h0);
      chk("async_rst_id_inst", fq_bus.id_inst, NOP);
      chk("async_rst_fq_ready", 32'(fq_bus.fq_ready), 32'd1);
      chk("async_rst_fq_count", 32'(fq_bus.fq_count), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (4) do_cycle(1'b0, 1'b1, 1'b0);

      // Fresh fetch after reset.
      next_pc = 32'h400;
      do_cycle(1'b1, 1'b1, 1'b0);
      repeat (3) do_cycle(1'b0, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
